// File: rtl/phased_array_pkg.sv
// phased_array_pkg: shared defaults and helpers for the phased-array transmitter.
//   PERIOD_DEF / HALF_DEF      : carrier period and high time in clk24 cycles
//   N_SPK_DEF / PHASE_STEP_DEF : channel count and per-channel phase step
//   CNT_W_DEF                  : carrier counter width for the default period
//   chan_off(i, step, period)  : elaboration-time phase offset of channel i
package phased_array_pkg;

    localparam int PERIOD_DEF     = 600;
    localparam int HALF_DEF       = 300;
    localparam int N_SPK_DEF      = 37;
    localparam int PHASE_STEP_DEF = 16;
    localparam int CNT_W_DEF      = $clog2(PERIOD_DEF);

    // Offset wraps modulo the period, so step*(N-1) may exceed PERIOD.
    function automatic int chan_off(input int i,
                                    input int step   = PHASE_STEP_DEF,
                                    input int period = PERIOD_DEF);
        return (i * step) % period;
    endfunction

endpackage

// File: rtl/spk_phase_gen.sv
// spk_phase_gen: one transducer channel.
//   clk24, rst_n : clock, async active-low reset
//   cnt          : shared carrier counter, 0..PERIOD-1
//   en           : transmit enable
//   drive        : registered square wave, high while the channel phase < HALF
// Parameter OFF is this channel's phase offset in clocks (0..PERIOD-1).
module spk_phase_gen #(
    parameter int PERIOD = 600,
    parameter int HALF   = 300,
    parameter int CNT_W  = 10,
    parameter int OFF    = 0
) (
    input  logic             clk24,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    output logic             drive
);

    localparam logic [CNT_W:0] PER_V  = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0] OFF_V  = (CNT_W+1)'(OFF);
    localparam logic [CNT_W:0] HALF_V = (CNT_W+1)'(HALF);

    logic [CNT_W:0] sum;
    logic [CNT_W:0] d;

    // cnt + (PERIOD - OFF) stays below 2*PERIOD, which fits in CNT_W+1 bits,
    // so one conditional subtract yields the phase without ever going negative.
    always_comb begin
        sum = {1'b0, cnt} + (PER_V - OFF_V);
        d   = sum;
        if (sum >= PER_V)
            d = sum - PER_V;
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            drive <= 1'b0;
        else
            drive <= en && (d < HALF_V);
    end

endmodule

// File: rtl/top.sv
// top: phased-array 40 kHz transmitter, one square wave per transducer with a
// linearly increasing phase offset (static steered beam).
//   clk24    : 24 MHz board clock
//   rst_n    : async active-low reset
//   speakers : N_SPK registered drive bits, bit i = channel i
// Optional feature macro BURST_EN: gates the carrier into pings of
// BURST_PERIODS carrier periods every PING_PERIODS periods. Without it the
// carrier is continuous.
module top
    import phased_array_pkg::*;
#(
    parameter int PERIOD        = PERIOD_DEF,
    parameter int HALF          = HALF_DEF,
    parameter int N_SPK         = N_SPK_DEF,
    parameter int PHASE_STEP    = PHASE_STEP_DEF,
    parameter int BURST_PERIODS = 8,
    parameter int PING_PERIODS  = 100
) (
    input  logic             clk24,
    input  logic             rst_n,
    output logic [N_SPK-1:0] speakers
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic             en;
    logic             wrap;

    assign wrap = (cnt == CNT_MAX);

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

`ifdef BURST_EN
    localparam int PW = (PING_PERIODS > 1) ? $clog2(PING_PERIODS) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PING_PERIODS - 1);

    logic [PW-1:0] pcnt;

    // Counts carrier periods within a ping interval; advances on the same
    // edge the carrier counter wraps, so gating lines up with period starts.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else if (wrap)
            pcnt <= (pcnt == PCNT_MAX) ? '0 : pcnt + PW'(1);
    end

    assign en = (int'(pcnt) < BURST_PERIODS);
`else
    assign en = 1'b1;
`endif

    for (genvar i = 0; i < N_SPK; i++) begin : g_spk
        spk_phase_gen #(
            .PERIOD (PERIOD),
            .HALF   (HALF),
            .CNT_W  (CNT_W),
            .OFF    (chan_off(i, PHASE_STEP, PERIOD))
        ) u_spk (
            .clk24 (clk24),
            .rst_n (rst_n),
            .cnt   (cnt),
            .en    (en),
            .drive (speakers[i])
        );
    end

endmodule

// File: tb/tb_top.sv
// tb_top: self-checking bench for top. A behavioural model computes every
// channel's expected level from the edge count since reset release; a compare
// process checks the full output vector every cycle, and literal checks pin
// the model at the edges that matter.
module tb_top;

    localparam int PERIOD = 600;
    localparam int HALF   = 300;
    localparam int N_SPK  = 37;
    localparam int STEP   = 16;
`ifdef BURST_EN
    localparam int BURST  = 1;
    localparam int PING   = 4;
`else
    localparam int BURST  = 8;
    localparam int PING   = 100;
`endif
    localparam int HMAX   = 3000;

    logic             clk24 = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_SPK-1:0] speakers;

    int tests = 0;
    int fails = 0;
    int k     = 0;   // edges since reset release
    logic [N_SPK-1:0] hist [0:HMAX];

    top #(
        .PERIOD(PERIOD), .HALF(HALF), .N_SPK(N_SPK), .PHASE_STEP(STEP),
        .BURST_PERIODS(BURST), .PING_PERIODS(PING)
    ) dut (
        .clk24    (clk24),
        .rst_n    (rst_n),
        .speakers (speakers)
    );

    always #5 clk24 = ~clk24;

    always @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // Expected vector at edge n: edge n samples carrier time t = n-1.
    function automatic logic [N_SPK-1:0] model(input int n);
        logic [N_SPK-1:0] v;
        int t, off, ph;
        bit on;
        v = '0;
        if (n == 0) return v;
        t = n - 1;
`ifdef BURST_EN
        on = ((t / PERIOD) % PING) < BURST;
`else
        on = 1'b1;
`endif
        for (int i = 0; i < N_SPK; i++) begin
            off  = (i * STEP) % PERIOD;
            ph   = ((t % PERIOD) - off + PERIOD) % PERIOD;
            v[i] = on && (ph < HALF);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [N_SPK-1:0] act,
                         input logic [N_SPK-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 30)
                $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input int edge_n, input int ch,
                             input logic exp);
        tests++;
        if (hist[edge_n][ch] !== exp) begin
            fails++;
            $display("FAIL %s: edge %0d ch %0d got %b want %b",
                     name, edge_n, ch, hist[edge_n][ch], exp);
        end
    endtask

    // Per-cycle compare against the model, sampled away from the active edge.
    always @(negedge clk24) begin
        check("model", speakers, model(k));
        if (k <= HMAX) hist[k] <= speakers;
    end

    task automatic run_to(input int n);
        while (k < n) @(negedge clk24);
        @(negedge clk24);   // hist[n] is written by this negedge
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk24);
        rst_n = 1'b1;
    endtask

    task automatic hit_reset(input int hold);
        @(posedge clk24);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", speakers, '0);
        repeat (hold) @(negedge clk24);
    endtask

    initial begin
        int spacing_bad, last, first, hi;
        // Reset held for 5 clocks: outputs must stay 0.
        repeat (5) begin
            @(negedge clk24);
            check("reset_zero", speakers, '0);
        end
        release_reset();

`ifdef BURST_EN
        run_to(2401);
        check_bit("burst_e1_ch0", 1, 0, 1'b1);
        check_bit("burst_e300_ch0", 300, 0, 1'b1);
        check_bit("burst_e17_ch1", 17, 1, 1'b1);
        begin
            int nz;
            nz = 0;
            for (int e = 601; e <= 2400; e++) if (hist[e] != '0) nz++;
            tests++;
            if (nz != 0) begin
                fails++;
                $display("FAIL burst_gap: %0d nonzero edges want 0", nz);
            end
        end
        check_bit("burst_resume_ch0", 2401, 0, 1'b1);
`else
        run_to(1300);
        check_bit("e1_ch0", 1, 0, 1'b1);
        check_bit("e1_ch1", 1, 1, 1'b0);
        check_bit("e300_ch0", 300, 0, 1'b1);
        check_bit("e301_ch0", 301, 0, 1'b0);
        check_bit("e600_ch0", 600, 0, 1'b0);
        check_bit("e601_ch0", 601, 0, 1'b1);
        check_bit("e1200_ch0", 1200, 0, 1'b0);
        check_bit("e1201_ch0", 1201, 0, 1'b1);
        check_bit("e16_ch1", 16, 1, 1'b0);
        check_bit("e17_ch1", 17, 1, 1'b1);
        check_bit("e576_ch36", 576, 36, 1'b0);
        check_bit("e577_ch36", 577, 36, 1'b1);
        check_bit("e276_ch36", 276, 36, 1'b1);
        check_bit("e277_ch36", 277, 36, 1'b0);

        // Transition spacing and duty per channel.
        for (int i = 0; i < N_SPK; i++) begin
            spacing_bad = 0; last = -1; first = 1; hi = 0;
            for (int e = 1; e <= 1000; e++) begin
                if (hist[e][i] != hist[e-1][i]) begin
                    if (!first && (e - last) != HALF) spacing_bad++;
                    if (last >= 0) first = 0;
                    last = e;
                end
            end
            for (int e = 601; e <= 1200; e++) hi += int'(hist[e][i]);
            tests++;
            if (spacing_bad != 0 || hi != HALF) begin
                fails++;
                $display("FAIL duty_ch%0d: bad_spacing %0d high %0d want 0/%0d",
                         i, spacing_bad, hi, HALF);
            end
        end
`endif

        // Mid-run reset at edge 450; channel 0 timing must restart from edge 1.
        rst_n = 1'b0;
        repeat (2) @(negedge clk24);
        release_reset();
        while (k < 450) @(negedge clk24);
        hit_reset(3);
        release_reset();
        run_to(610);
        check_bit("rst_e1_ch0", 1, 0, 1'b1);
        check_bit("rst_e300_ch0", 300, 0, 1'b1);
        check_bit("rst_e301_ch0", 301, 0, 1'b0);
        check_bit("rst_e17_ch1", 17, 1, 1'b1);

        // Random reset points and durations; the compare process does the rest.
        for (int r = 0; r < 6; r++) begin
            int at;
            at = int'($urandom_range(1, 1500));
            while (k < at) @(negedge clk24);
            hit_reset(int'($urandom_range(1, 6)));
            release_reset();
        end
        repeat (700) @(negedge clk24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/top.md
# top

Top-level phased-array transmitter for the sonar board. From the 24 MHz board clock it derives a 40 kHz square-wave drive for each of 37 ultrasonic transducers. Each channel has a fixed, linearly increasing phase offset, which gives a static steered beam. The block is the FPGA top level and drives the `speakers` pins directly.

## Interface
Parameters:
- `PERIOD`, default 600: clocks per carrier period (24 MHz / 40 kHz).
- `HALF`, default 300: clocks high per period.
- `N_SPK`, default 37: number of transducer channels.
- `PHASE_STEP`, default 16: phase offset increment per channel, in clocks.
- `BURST_PERIODS`, default 8: carrier periods transmitted per ping (used only with `BURST_EN`).
- `PING_PERIODS`, default 100: carrier periods per ping interval (used only with `BURST_EN`).

Ports:
- `clk24`, input, 1 bit: 24 MHz clock. This is the only clock.
- `rst_n`, input, 1 bit: reset. Asynchronous assert, active-low.
- `speakers`, output, `N_SPK` (37) bits: transducer drive. Bit i drives channel i.

## Operation
- **Carrier counter** `cnt`:
  - Width is `$clog2(PERIOD)` (10 bits).
  - Counts 0..`PERIOD`-1 and wraps to 0.
- **Channel offset**: `off_i = (i*PHASE_STEP) mod PERIOD`.
  - This is an elaboration-time constant.
  - With the defaults, `off_0`=0, `off_1`=16, …, `off_36`=576.
- **Channel phase**: `d_i = cnt - off_i` when `cnt >= off_i`, otherwise `cnt + PERIOD - off_i`.
  - No negative or out-of-range intermediate value is allowed.
- **Channel drive**: `speakers[i]` is registered and equals `en && (d_i < HALF)`.
  - With the defaults, channel i is high for `cnt` in [off_i, off_i+299], taken mod 600.
- **Enable** `en`:
  - Constant 1 when `BURST_EN` is undefined.
  - Gated as described in Configuration when `BURST_EN` is defined.
- **Duty cycle**: all channels run at exactly 50 % duty (`HALF`/`PERIOD`) with the same frequency. Only the phase differs between channels.
- **Parameter legality**: `PHASE_STEP*(N_SPK-1)` may exceed `PERIOD`. The mod reduction handles this; the offset wraps.

## Timing
- **During reset**: `cnt`=0 and `speakers`=0 (all 37 bits).
- **First edges after reset release**:
  - At the first rising edge, `speakers` is computed from `cnt`=0.
  - At the same edge, `cnt` becomes 1.
- **Output latency**: one clock. `speakers` at edge k (k≥1) reflects `cnt`=(k-1) mod `PERIOD`.
- **Channel 0**:
  - High on edges 1..300.
  - Low on edges 301..600.
  - High again from edge 601.
- **Channel i**: rises on edge `off_i`+1 after reset and on every 600th edge after that. When `off_i`=0 it rises on edge 1.
- **Wrap-around**: `cnt`=599 is followed by 0 on the next edge. There is no glitch or skipped value.
- **Reset mid-operation**: `speakers` clears asynchronously on the `rst_n` fall. All phases restart from `cnt`=0 on release.
- **Output glitches**: none. Every output bit comes directly from a flop.

## Configuration
- **Macro**: `BURST_EN`.
- **When defined**:
  - A ping counter `pcnt` (0..`PING_PERIODS`-1) increments when `cnt` wraps 599→0.
  - `en` = (`pcnt` < `BURST_PERIODS`).
  - With the defaults, every 100 periods the block transmits 8 periods, then holds all outputs 0 for 92 periods.
  - `pcnt` resets to 0, so transmission starts immediately after reset.
- **When undefined**:
  - `en` is tied to 1, so the carrier is continuous.
  - `pcnt` is not instantiated.

## Structure
- **Package** `phased_array_pkg` holds:
  - the defaults for `PERIOD`, `HALF`, `N_SPK` and `PHASE_STEP`;
  - the counter-width localparam;
  - the offset function `chan_off(i)`.
- **Sub-module** `spk_phase_gen` generates one channel.
  - Parameter: `OFF`.
  - Inputs: `clk24`, `rst_n`, `cnt`, `en`.
  - Output: one registered bit.
  - `top` instantiates it `N_SPK` times in a generate loop.
- `top` contains the carrier counter and the optional burst counter.

## Test plan
- **Reset**: hold `rst_n`=0 for 5 clocks. Require `speakers`=37'h0 throughout. Release; at edge 1 require `speakers[0]`=1 and `speakers[1]`=0.
- **Channel 0 waveform**: require high for 300 edges, then low for 300 edges. Require rising edges at edges 1, 601 and 1201.
- **Channel phase offsets**: require `speakers[1]` rising at edge 17, `speakers[36]` rising at edge 577, and `speakers[36]` falling at edge 277 (wrapped high window 576..275).
- **Duty and frequency**: over 1000 edges, count high cycles per channel. Require each channel's transition spacing to be 300 clocks once started.
- **Mid-run reset**: assert `rst_n`=0 at edge 450. Require all outputs to go 0 immediately. After release, require the channel 0 timing to repeat from edge 1.
- **Burst** (`BURST_EN`, `PING_PERIODS`=4, `BURST_PERIODS`=1): require the carrier on edges 1..600, all zero on edges 601..2400, and the carrier resuming at edge 2401.
